// File: rtl/traffic_phase_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg: shared definitions for the two-approach phase scheduler.
//   RED / YELLOW / GREEN : 3-bit signal-head codes, {Red, Yellow, Green}.
//   phase_t              : scheduler state, also driven out as the debug phase.
//   phase_lights()       : {LA, LB} decode for a given phase.
// ---------------------------------------------------------------------------
package traffic_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    typedef enum logic [2:0] {
        A_GRN    = 3'd0,
        A_YEL    = 3'd1,
        RED_AB   = 3'd2,
        B_GRN    = 3'd3,
        B_YEL    = 3'd4,
        RED_BA   = 3'd5,
        PED_WALK = 3'd6
    } phase_t;

    // Returns {LA, LB}. Every phase other than a green/yellow is all-red.
    function automatic logic [5:0] phase_lights(phase_t p);
        logic [5:0] l;
        l = {RED, RED};
        case (p)
            A_GRN:   l = {GREEN,  RED};
            A_YEL:   l = {YELLOW, RED};
            B_GRN:   l = {RED,    GREEN};
            B_YEL:   l = {RED,    YELLOW};
            default: l = {RED,    RED};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// ---------------------------------------------------------------------------
// traffic_phase_scheduler_if: signal bundle between the controller and the
// surrounding system (clk/reset stay plain ports on the scheduler).
//   tick, TA, TB, ped_req          : system -> scheduler
//   LA, LB, walk, phase, ped_pending : scheduler -> system
// modport master : the system side (drives inputs, observes lights).
// modport slave  : the scheduler side.
// ---------------------------------------------------------------------------
interface traffic_phase_scheduler_if;

    logic       tick;
    logic       TA;
    logic       TB;
    logic       ped_req;
    logic [2:0] LA;
    logic [2:0] LB;
    logic       walk;
    logic [2:0] phase;
    logic       ped_pending;

    modport master (
        output tick, TA, TB, ped_req,
        input  LA, LB, walk, phase, ped_pending
    );

    modport slave (
        input  tick, TA, TB, ped_req,
        output LA, LB, walk, phase, ped_pending
    );

endinterface

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer: CNT_W-bit phase timer.
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : clear (phase entry); wins over tick_i
//   tick_i     : time-base enable; count advances by one per tick
//   count_o    : current count, saturating at SAT
// ---------------------------------------------------------------------------
module phase_timer #(
    parameter int CNT_W = 4,
    parameter int SAT   = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             tick_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] SAT_V = CNT_W'(SAT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (tick_i && (count_q != SAT_V)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// ---------------------------------------------------------------------------
// traffic_phase_scheduler: two-approach (A / B) intersection phase scheduler
// with min/max green, yellow, all-red clearance and an optional all-red
// pedestrian walk phase. All timing advances on bus.tick only.
//   clk, reset : clock, synchronous active-high reset (forces A_GRN)
//   bus        : traffic_phase_scheduler_if.slave
//                in : tick, TA, TB, ped_req
//                out: LA, LB ({R,Y,G}), walk, phase (debug), ped_pending
// Build option: define TRAFFIC_PED_EN to include the pedestrian path; when
// undefined ped_req is ignored and walk / ped_pending are held at 0.
// ---------------------------------------------------------------------------
import traffic_pkg::*;

module traffic_phase_scheduler #(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 12,
    parameter int YELLOW_T  = 3,
    parameter int ALL_RED_T = 1,
    parameter int WALK_T    = 6,
    parameter int CNT_W     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    traffic_phase_scheduler_if.slave  bus
);

    localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] YEL_V = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] RED_V = CNT_W'(ALL_RED_T);
`ifdef TRAFFIC_PED_EN
    localparam logic [CNT_W-1:0] WLK_V = CNT_W'(WALK_T);
`endif

    phase_t           state_q;
    phase_t           state_d;
    logic [2:0]       la_q;
    logic [2:0]       lb_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] n_inc;
    logic             leave;
    logic             demand_a;   // request to leave A green
    logic             demand_b;   // request to leave B green

    phase_timer #(
        .CNT_W (CNT_W),
        .SAT   (MAX_GREEN)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (leave),
        .tick_i  (bus.tick),
        .count_o (n_q)
    );

    // Transition tests look at the count as it will be after this tick.
    assign n_inc = (n_q == MAX_V) ? n_q : n_q + 1'b1;

`ifdef TRAFFIC_PED_EN
    logic ped_q;
    logic ped_d;
    logic last_b_q;   // 1: B was the last approach given green
    logic last_b_d;
    logic walk_q;

    assign demand_a = bus.TB | ped_q;
    assign demand_b = bus.TA | ped_q;
`else
    assign demand_a = bus.TB;
    assign demand_b = bus.TA;
`endif

    always_comb begin
        state_d = state_q;
        if (bus.tick) begin
            case (state_q)
                A_GRN:
                    if (demand_a && (((n_inc >= MIN_V) && !bus.TA) || (n_inc >= MAX_V)))
                        state_d = A_YEL;
                A_YEL:
                    if (n_inc == YEL_V) state_d = RED_AB;
                RED_AB:
                    if (n_inc == RED_V) begin
`ifdef TRAFFIC_PED_EN
                        state_d = ped_q ? PED_WALK : B_GRN;
`else
                        state_d = B_GRN;
`endif
                    end
                B_GRN:
                    if (demand_b && (((n_inc >= MIN_V) && !bus.TB) || (n_inc >= MAX_V)))
                        state_d = B_YEL;
                B_YEL:
                    if (n_inc == YEL_V) state_d = RED_BA;
                RED_BA:
                    if (n_inc == RED_V) begin
`ifdef TRAFFIC_PED_EN
                        state_d = ped_q ? PED_WALK : A_GRN;
`else
                        state_d = A_GRN;
`endif
                    end
`ifdef TRAFFIC_PED_EN
                PED_WALK:
                    if (n_inc == WLK_V) state_d = last_b_q ? A_GRN : B_GRN;
`endif
                default:
                    state_d = A_GRN;
            endcase
        end
    end

    assign leave = (state_d != state_q);

`ifdef TRAFFIC_PED_EN
    // Entering the walk serves the request, including a press in that cycle.
    always_comb begin
        ped_d    = ped_q | bus.ped_req;
        last_b_d = last_b_q;
        if (leave && (state_d == PED_WALK)) ped_d    = 1'b0;
        if (leave && (state_d == A_GRN))    last_b_d = 1'b0;
        if (leave && (state_d == B_GRN))    last_b_d = 1'b1;
    end
`endif

    // Lights are registered from the next state, so they always match state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= A_GRN;
            {la_q, lb_q} <= phase_lights(A_GRN);
`ifdef TRAFFIC_PED_EN
            walk_q       <= 1'b0;
            ped_q        <= 1'b0;
            last_b_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            {la_q, lb_q} <= phase_lights(state_d);
`ifdef TRAFFIC_PED_EN
            walk_q       <= (state_d == PED_WALK);
            ped_q        <= ped_d;
            last_b_q     <= last_b_d;
`endif
        end
    end

    assign bus.LA    = la_q;
    assign bus.LB    = lb_q;
    assign bus.phase = state_q;

`ifdef TRAFFIC_PED_EN
    assign bus.walk        = walk_q;
    assign bus.ped_pending = ped_q;
`else
    logic unused_ped_req;
    assign unused_ped_req  = bus.ped_req;
    assign bus.walk        = 1'b0;
    assign bus.ped_pending = 1'b0;
`endif

endmodule
